start_bit_qualifier: RTL and testbench
======================================

// Module: start_bit_qualifier
// PURPOSE
//  Parametrised UART receive front end that replaces bare falling-edge start detection.
//  Synchronises the async RX line and detects a falling edge.
//  Confirms the start bit at its mid-point using the oversample tick; short glitches are
//  reported as false starts. Also flags line-break and blocks re-triggering until the
//  receiver re-arms it. Sits between the RX pad and the UART receive controller.
// PARAMETERS
//  SYNC_STAGES  2    synchroniser flops on data_in; legal >= 2
//  OVERSAMPLE   16   sample_en ticks per bit; even; legal >= 4
//  BREAK_BITS   10   bit-times of continuous low that count as a line break; legal >= 1
// PORTS
//  clk             in   1  system clock
//  n_Rst           in   1  async active-low reset
//  data_in         in   1  raw RX line, asynchronous, idles high
//  sample_en       in   1  one-clk oversample strobe, OVERSAMPLE per bit
//  rearm           in   1  one-clk pulse from receiver: frame finished
//  line_sync       out  1  synchronised RX line (last synchroniser stage)
//  start_detected  out  1  one-clk pulse: start bit confirmed at mid-bit
//  false_start     out  1  one-clk pulse: edge rejected as a glitch
//  busy            out  1  high from edge detect until re-armed and line high
//  break_detected  out  1  level: line low >= BREAK_BITS*OVERSAMPLE ticks
// BEHAVIOUR
//  Reset: every sync flop and line_prev = 1; state = IDLE; counters = 0.
//   line_sync = 1; start_detected, false_start, busy and break_detected = 0.
//  Sync: data_in -> line_sync latency is SYNC_STAGES clks. line_prev <= line_sync every clk.
//   fall = line_prev & ~line_sync. fall is evaluated every clk and does not depend on sample_en.
//  FSM states: IDLE, CHECK, BUSY, WAIT_HIGH.
//  IDLE: on fall, go to CHECK and set mid_cnt = 0. rearm is ignored.
//  CHECK, on each sample_en:
//   - line_sync = 1: pulse false_start and go to IDLE.
//   - Else if mid_cnt == OVERSAMPLE/2-1: pulse start_detected and go to BUSY.
//   - Else: mid_cnt++.
//   fall events in CHECK are ignored. mid_cnt width = $clog2(OVERSAMPLE).
//  BUSY: line activity is ignored. On rearm: go to IDLE if line_sync = 1, else to WAIT_HIGH.
//  WAIT_HIGH: go to IDLE on the first clk with line_sync = 1. No fall is taken while here.
//   This prevents re-triggering on a held-low line.
//  busy = (state != IDLE), registered.
//   Asserts the clk after the fall is taken; deasserts the clk after the return to IDLE.
//  Pulse timing: start_detected and false_start are registered.
//   Each is high for exactly 1 clk, the clk after the qualifying sample_en.
//   They never assert together.
//  Break: brk_cnt counts sample_en ticks while line_sync = 0, in any state.
//   brk_cnt clears on any clk with line_sync = 1 and saturates at BREAK_BITS*OVERSAMPLE.
//   break_detected = 1 while brk_cnt is saturated; it clears the clk after line_sync returns
//   to 1. Width = $clog2(BREAK_BITS*OVERSAMPLE+1).
//  Simultaneous events:
//   - rearm together with sample_en in BUSY: rearm is honoured.
//   - fall together with sample_en in IDLE: go to CHECK; that tick is not counted.
//  n_Rst asserted mid-frame: all state returns to reset values immediately; no pulse is emitted.
// TESTING
//  T1 reset: hold n_Rst = 0 with data_in = 0.
//     -> line_sync = 1, busy = 0, all pulses = 0, break_detected = 0.
//  T2 valid start, OVERSAMPLE = 16: drive data_in low for 16 ticks.
//     -> start_detected pulses once, the clk after tick 8; busy stays high until rearm.
//  T3 glitch: drive data_in low for 3 ticks, then high.
//     -> false_start pulses once on tick 4; no start_detected; busy returns to 0.
//  T4 held low: send a valid start, then pulse rearm with data_in still low.
//     -> state is WAIT_HIGH with no new start. Raising the line -> IDLE.
//     -> The next falling edge gives a new start_detected.
//  T5 break, BREAK_BITS = 10: hold data_in low for 160 ticks.
//     -> break_detected = 1 from tick 160; it clears 1 clk after line_sync returns high.
//  T6 reset mid-CHECK: assert n_Rst at tick 5 of a start bit.
//     -> no pulse is produced; outputs return to reset values.

Source files
------------

// File: rtl/start_bit_qualifier.sv
// start_bit_qualifier: synchronises the UART RX line, confirms start bits at mid-bit,
// rejects glitches as false starts and flags line breaks
module start_bit_qualifier #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16,
    parameter int BREAK_BITS  = 10
) (
    input  logic clk,
    input  logic n_Rst,
    input  logic data_in,
    input  logic sample_en,
    input  logic rearm,
    output logic line_sync,
    output logic start_detected,
    output logic false_start,
    output logic busy,
    output logic break_detected
);
    localparam int MID_W   = $clog2(OVERSAMPLE);
    localparam int BRK_MAX = BREAK_BITS * OVERSAMPLE;
    localparam int BRK_W   = $clog2(BRK_MAX + 1);
    localparam logic [MID_W-1:0] MID_LAST = MID_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BRK_W-1:0] BRK_SAT  = BRK_W'(BRK_MAX);

    typedef enum logic [1:0] {IDLE, CHECK, BUSY, WAIT_HIGH} state_t;

    state_t state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic line_prev;
    logic fall;
    logic [MID_W-1:0] mid_cnt;
    logic [BRK_W-1:0] brk_cnt;

    assign line_sync      = sync_q[SYNC_STAGES-1];
    assign fall           = line_prev & ~line_sync;
    assign break_detected = brk_cnt == BRK_SAT;

    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            sync_q    <= '1;
            line_prev <= 1'b1;
            brk_cnt   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], data_in};
            line_prev <= line_sync;
            brk_cnt   <= line_sync ? '0 : (sample_en && brk_cnt != BRK_SAT) ? brk_cnt + 1'b1 : brk_cnt;
        end
    end

    // busy mirrors the previous state, so it trails every state change by one clk
    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            state          <= IDLE;
            mid_cnt        <= '0;
            start_detected <= 1'b0;
            false_start    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            start_detected <= 1'b0;
            false_start    <= 1'b0;
            busy           <= state != IDLE;
            case (state)
                IDLE: if (fall) begin
                    state   <= CHECK;
                    mid_cnt <= '0;
                end
                CHECK: if (sample_en) begin
                    if (line_sync) begin
                        false_start <= 1'b1;
                        state       <= IDLE;
                    end else if (mid_cnt == MID_LAST) begin
                        start_detected <= 1'b1;
                        state          <= BUSY;
                    end else begin
                        mid_cnt <= mid_cnt + 1'b1;
                    end
                end
                BUSY: if (rearm) state <= line_sync ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (line_sync) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_start_bit_qualifier.sv
// tb_start_bit_qualifier: directed bench with a behavioural model checked every cycle
module tb_start_bit_qualifier;
    localparam int SYNC = 2, OS = 16, BB = 10, BRK_MAX = BB * OS;

    logic clk = 1'b0;
    logic n_Rst, data_in, sample_en, rearm;
    logic line_sync, start_detected, false_start, busy, break_detected;

    int checks = 0, failures = 0, sd_cnt = 0, fs_cnt = 0, tick_no = 0, start_tick = -1;
    int s0, f0;

    logic q[$];
    int m_mode, m_ticks, m_brk;
    logic m_prev, m_line, e_start, e_false, e_busy;

    always #5 clk = ~clk;

    start_bit_qualifier #(.SYNC_STAGES(SYNC), .OVERSAMPLE(OS), .BREAK_BITS(BB)) dut (
        .clk(clk), .n_Rst(n_Rst), .data_in(data_in), .sample_en(sample_en), .rearm(rearm),
        .line_sync(line_sync), .start_detected(start_detected), .false_start(false_start),
        .busy(busy), .break_detected(break_detected)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // modes: 0 idle, 1 qualifying, 2 in frame, 3 waiting for line high
    task automatic model_reset();
        q.delete();
        repeat (SYNC) q.push_back(1'b1);
        m_line = 1'b1; m_prev = 1'b1; m_mode = 0; m_ticks = 0; m_brk = 0;
        e_start = 1'b0; e_false = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_update();
        logic ls, fl;
        ls = m_line;
        fl = m_prev & ~ls;
        e_busy = m_mode != 0;
        e_start = 1'b0;
        e_false = 1'b0;
        case (m_mode)
            0: if (fl) begin m_mode = 1; m_ticks = 0; end
            1: if (sample_en) begin
                if (ls) begin e_false = 1'b1; m_mode = 0; end
                else begin
                    m_ticks++;
                    if (m_ticks == OS / 2) begin e_start = 1'b1; m_mode = 2; end
                end
            end
            2: if (rearm) m_mode = ls ? 0 : 3;
            default: if (ls) m_mode = 0;
        endcase
        m_brk = ls ? 0 : (sample_en && m_brk < BRK_MAX) ? m_brk + 1 : m_brk;
        m_prev = ls;
        q.push_back(data_in);
        void'(q.pop_front());
        m_line = q[0];
    endtask

    task automatic step(input logic d, input logic se, input logic ra);
        data_in = d; sample_en = se; rearm = ra;
        @(posedge clk);
        if (n_Rst) model_update();
        #1;
    endtask

    task automatic tick(input logic d);
        tick_no++;
        step(d, 1'b1, 1'b0);
        if (start_detected && start_tick < 0) start_tick = tick_no;
        step(d, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        chk("line_sync", line_sync, m_line);
        chk("start_detected", start_detected, e_start);
        chk("false_start", false_start, e_false);
        chk("busy", busy, e_busy);
        chk("break_detected", break_detected, m_brk == BRK_MAX);
        if (start_detected) sd_cnt++;
        if (false_start) fs_cnt++;
    end

    initial begin
        n_Rst = 1'b0; data_in = 1'b0; sample_en = 1'b0; rearm = 1'b0;
        model_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("t1_line", line_sync, 1);
        chk("t1_busy", busy, 0);
        chk("t1_start", start_detected, 0);
        chk("t1_false", false_start, 0);
        chk("t1_break", break_detected, 0);
        data_in = 1'b1;
        n_Rst = 1'b1;
        repeat (4) step(1'b1, 1'b0, 1'b0);

        tick_no = 0; start_tick = -1; s0 = sd_cnt;
        repeat (16) tick(1'b0);
        chk("t2_starts", sd_cnt - s0, 1);
        chk("t2_start_tick", start_tick, 10);
        chk("t2_busy", busy, 1);
        repeat (2) tick(1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        chk("t2_rearmed", busy, 0);

        s0 = sd_cnt; f0 = fs_cnt;
        repeat (4) tick(1'b0);
        repeat (3) tick(1'b1);
        chk("t3_false", fs_cnt - f0, 1);
        chk("t3_starts", sd_cnt - s0, 0);
        chk("t3_busy", busy, 0);

        s0 = sd_cnt;
        repeat (16) tick(1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (20) tick(1'b0);
        chk("t4_held_starts", sd_cnt - s0, 1);
        chk("t4_held_busy", busy, 1);
        repeat (2) tick(1'b1);
        chk("t4_idle", busy, 0);
        repeat (16) tick(1'b0);
        chk("t4_restart", sd_cnt - s0, 2);
        repeat (2) tick(1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0);

        repeat (160) tick(1'b0);
        chk("t5_pre_break", break_detected, 0);
        tick(1'b0);
        chk("t5_break", break_detected, 1);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        chk("t5_line_high", line_sync, 1);
        chk("t5_break_hold", break_detected, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_break_clear", break_detected, 0);
        step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0);

        s0 = sd_cnt; f0 = fs_cnt;
        repeat (5) tick(1'b0);
        chk("t6_checking", busy, 1);
        n_Rst = 1'b0;
        model_reset();
        #1;
        chk("t6_line", line_sync, 1);
        chk("t6_busy", busy, 0);
        chk("t6_start", start_detected, 0);
        chk("t6_false", false_start, 0);
        chk("t6_break", break_detected, 0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        chk("t6_no_start", sd_cnt - s0, 0);
        chk("t6_no_false", fs_cnt - f0, 0);
        data_in = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        n_Rst = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
